// File: rtl/d_pipeline_reg.sv
// Elastic pipeline register: DEPTH stages of WIDTH-bit registers with a
// valid bit per stage. Ready ripples back from the output, so empty stages
// are filled by the data behind them (bubble collapse). The block also has a
// synchronous flush and a registered occupancy count.

// One pipeline stage: a valid bit plus a data word, loaded from its
// upstream source whenever the chain lets this stage advance.
module d_pipeline_reg_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             adv_i,
    input  logic             src_v_i,
    input  logic [WIDTH-1:0] src_d_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);
    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Next state: flush drops the valid bit only; the data word becomes a
    // don't-care and is left alone. A stalled stage keeps its word.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (adv_i) begin
            v_d = src_v_i;
            d_d = src_d_i;
        end
    end

    // Stage registers; reset also clears the data so out_data reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;
endmodule

module d_pipeline_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            stage_v;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic [DEPTH-1:0]            adv;
    logic                        adv_run;
    logic                        accept;
    logic                        consume;
    logic [CNT_W-1:0]            count_q, count_d;

    // Advance chain: a stage may load when everything downstream moves or
    // when it is itself empty. This is the documented combinational path
    // from out_ready back to in_ready; in_valid never reaches out_valid.
    always_comb begin
        adv     = '0;
        adv_run = out_ready | ~stage_v[DEPTH-1];
        adv[DEPTH-1] = adv_run;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv_run = adv_run | ~stage_v[i];
            adv[i]  = adv_run;
        end
    end

    assign in_ready  = adv[0];
    assign accept    = in_valid & in_ready;
    assign out_valid = stage_v[DEPTH-1];
    assign out_data  = stage_d[DEPTH-1];
    assign consume   = out_valid & out_ready;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign src_v[g] = accept;
                assign src_d[g] = in_data;
            end else begin : g_body
                assign src_v[g] = stage_v[g-1];
                assign src_d[g] = stage_d[g-1];
            end

            d_pipeline_reg_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .reset   (reset),
                .flush   (flush),
                .adv_i   (adv[g]),
                .src_v_i (src_v[g]),
                .src_d_i (src_d[g]),
                .v_o     (stage_v[g]),
                .d_o     (stage_d[g])
            );
        end
    endgenerate

    // Occupancy: tracks accepts minus consumes; a flush empties every stage.
    always_comb begin
        count_d = count_q + CNT_W'(accept) - CNT_W'(consume);
        if (flush) begin
            count_d = '0;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: tb/tb_d_pipeline_reg.sv
// Bench for d_pipeline_reg: a WIDTH=8/DEPTH=3 instance and a WIDTH=16/DEPTH=1
// instance, each with a scoreboard queue fed on accept and drained on consume.
module tb_d_pipeline_reg;
    logic        clk = 1'b0;
    logic        reset, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_data, out_data;
    logic [1:0]  count;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [15:0] in_data1, out_data1;
    logic [0:0]  count1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [7:0]  sbq[$];
    logic [15:0] sbq1[$];
    logic [7:0]  exp8;
    logic [15:0] exp16;

    always #5 clk = ~clk;

    d_pipeline_reg #(.WIDTH(8), .DEPTH(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    d_pipeline_reg #(.WIDTH(16), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .count(count1)
    );

    // Scoreboard for the DEPTH=3 instance: pop on consume, push on accept,
    // discard everything in flight on flush/reset.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset) begin
                checks++;
                if (32'(count) !== sbq.size()) begin
                    errors++;
                    $display("FAIL sb_count: count=%0d expected=%0d", count, sbq.size());
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: out_data=%h expected=no word", out_data);
                end else begin
                    exp8 = sbq.pop_front();
                    if (out_data !== exp8) begin
                        errors++;
                        $display("FAIL sb_data: out_data=%h expected=%h", out_data, exp8);
                    end
                end
            end
            if (reset || flush) sbq.delete();
            else if (in_valid && in_ready) sbq.push_back(in_data);
        end
    end

    // Scoreboard for the DEPTH=1 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset) begin
                checks++;
                if (32'(count1) !== sbq1.size()) begin
                    errors++;
                    $display("FAIL sb1_count: count=%0d expected=%0d", count1, sbq1.size());
                end
            end
            if (out_valid1 && out_ready1) begin
                checks++;
                if (sbq1.size() == 0) begin
                    errors++;
                    $display("FAIL sb1_unexpected: out_data=%h expected=no word", out_data1);
                end else begin
                    exp16 = sbq1.pop_front();
                    if (out_data1 !== exp16) begin
                        errors++;
                        $display("FAIL sb1_data: out_data=%h expected=%h", out_data1, exp16);
                    end
                end
            end
            if (reset || flush) sbq1.delete();
            else if (in_valid1 && in_ready1) sbq1.push_back(in_data1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = 16'h0000; out_ready1 = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        checks += 8;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got=%b exp=0", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got=%h exp=00", out_data); end
        if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got=%0d exp=0", count); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got=%b exp=1", in_ready); end
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset1_out_valid: got=%b exp=0", out_valid1); end
        if (out_data1 !== 16'h0000) begin errors++; $display("FAIL reset1_out_data: got=%h exp=0000", out_data1); end
        if (count1 !== 1'd0) begin errors++; $display("FAIL reset1_count: got=%0d exp=0", count1); end
        if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset1_in_ready: got=%b exp=1", in_ready1); end
        mon_en = 1'b1;
    endtask

    // Three words back to back with the consumer always ready.
    task automatic test_latency();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = words[i];
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid%0d: got=%b exp=1", i, out_valid); end
            if (out_data !== words[i]) begin errors++; $display("FAIL lat_data%0d: got=%h exp=%h", i, out_data, words[i]); end
            if (count !== 2'(3 - i)) begin errors++; $display("FAIL lat_count%0d: got=%0d exp=%0d", i, count, 3 - i); end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_empty: got=%b exp=0", out_valid); end
    endtask

    // Consumer stalled: three words fill the pipe, the fourth waits.
    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA1 + 8'(i);
            n = 0;
            while (!in_ready && n < 20) begin tick(); n++; end
            checks++;
            if (n >= 20) begin errors++; $display("FAIL bp_accept%0d: in_ready=%b exp=1", i, in_ready); end
            tick();
        end
        in_data = 8'hA4;
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready%0d: got=%b exp=0", k, in_ready); end
            if (count !== 2'd3) begin errors++; $display("FAIL bp_full_count%0d: got=%0d exp=3", k, count); end
            if (out_data !== 8'hA1) begin errors++; $display("FAIL bp_head%0d: got=%h exp=a1", k, out_data); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (count != 0 && n < 20) begin tick(); n++; end
        checks += 2;
        if (count !== 2'd0) begin errors++; $display("FAIL bp_drain: count=%0d exp=0", count); end
        if (sbq.size() != 0) begin errors++; $display("FAIL bp_lost: pending=%0d exp=0", sbq.size()); end
    endtask

    // A single word slides all the way to the output while stalled.
    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bub_early: out_valid=%b exp=0", out_valid); end
        tick();
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bub_valid: got=%b exp=1", out_valid); end
        if (out_data !== 8'h5A) begin errors++; $display("FAIL bub_data: got=%h exp=5a", out_data); end
        if (count !== 2'd1) begin errors++; $display("FAIL bub_count: got=%0d exp=1", count); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_ready: got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++;
        if (count !== 2'd0) begin errors++; $display("FAIL bub_drain: count=%0d exp=0", count); end
    endtask

    // Flush in the middle of a stream; the flush-cycle word must vanish.
    task automatic test_flush();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h60 + 8'(i);
            tick();
        end
        flush   = 1'b1;
        in_data = 8'hEE;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks += 2;
        if (count !== 2'd0) begin errors++; $display("FAIL flush_count: got=%0d exp=0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got=%b exp=0", out_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d: out_valid=%b out_data=%h exp=0", i, out_valid, out_data); end
        end
    endtask

    // Full pipe hit by reset and flush together.
    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC1 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 2'd3) begin errors++; $display("FAIL rf_full: count=%0d exp=3", count); end
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got=%b exp=0", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL rf_data: got=%h exp=00", out_data); end
        if (count !== 2'd0) begin errors++; $display("FAIL rf_count: got=%0d exp=0", count); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_ready: got=%b exp=1", in_ready); end
    endtask

    // Random valid/ready traffic; ordering is checked by the scoreboard.
    task automatic test_random();
        int n;
        logic [7:0] seq = 8'h00;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = seq;
            #1;
            if (in_valid && in_ready) seq++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (count != 0 && n < 20) begin tick(); n++; end
        checks += 2;
        if (count !== 2'd0) begin errors++; $display("FAIL rnd_drain: count=%0d exp=0", count); end
        if (sbq.size() != 0) begin errors++; $display("FAIL rnd_lost: pending=%0d exp=0", sbq.size()); end
    endtask

    // Backpressure scenario on the single-register, 16-bit instance.
    task automatic test_depth1();
        int n;
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        in_data1   = 16'hB001;
        tick();
        in_data1 = 16'hB002;
        checks += 4;
        if (in_ready1 !== 1'b0) begin errors++; $display("FAIL d1_full_ready: got=%b exp=0", in_ready1); end
        if (count1 !== 1'd1) begin errors++; $display("FAIL d1_count: got=%0d exp=1", count1); end
        if (out_valid1 !== 1'b1) begin errors++; $display("FAIL d1_valid: got=%b exp=1", out_valid1); end
        if (out_data1 !== 16'hB001) begin errors++; $display("FAIL d1_data: got=%h exp=b001", out_data1); end
        tick();
        out_ready1 = 1'b1;
        #1;
        checks++;
        if (in_ready1 !== 1'b1) begin errors++; $display("FAIL d1_release: in_ready=%b exp=1", in_ready1); end
        for (int i = 1; i < 4; i++) begin
            in_data1 = 16'hB001 + 16'(i);
            n = 0;
            while (!in_ready1 && n < 20) begin tick(); n++; end
            checks++;
            if (n >= 20) begin errors++; $display("FAIL d1_accept%0d: in_ready=%b exp=1", i, in_ready1); end
            tick();
        end
        in_valid1 = 1'b0;
        n = 0;
        while (count1 != 0 && n < 20) begin tick(); n++; end
        checks += 2;
        if (count1 !== 1'd0) begin errors++; $display("FAIL d1_drain: count=%0d exp=0", count1); end
        if (sbq1.size() != 0) begin errors++; $display("FAIL d1_lost: pending=%0d exp=0", sbq1.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_bubble();
        test_flush();
        test_reset_full();
        test_random();
        test_depth1();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
